piso_shift_register: RTL and testbench

//   Parallel-in/serial-out transmitter. Accepts an N-bit word on a valid/ready handshake, then

---
 rtl/piso_shift_register_pkg.sv | 23 ++
 rtl/piso_shift_register_bit_counter.sv | 25 ++
 rtl/piso_shift_register.sv | 117 +++++++++++
 tb/tb_piso_shift_register.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/piso_shift_register_pkg.sv
// Shared definitions for the PISO transmitter: FSM state encoding and the
// ceil-log2 helper used to size bit counters.
package piso_shift_register_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Ceil(log2(v)), floored at 1 so a counter always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/piso_shift_register_bit_counter.sv
// Bit index counter for a word in flight: 0..N-1, with an exact terminal
// flag at N-1. Never wraps on its own; the owner clears it.
module bit_counter
  import piso_shift_register_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  assign terminal = (count == CW'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out transmitter: takes an N-bit word on valid/ready and
// streams it one bit per clock with a per-bit valid, busy and end-of-word done.
module piso_shift_register
  import piso_shift_register_pkg::*;
#(
  parameter int N         = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] D,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done
);

  localparam int CW = clog2(N);

  state_t        state, next_state;
  logic [N-1:0]  shreg;
  logic [CW-1:0] count;
  logic          terminal;
  logic          accept;
  logic          clear;
  logic          enable;

  function automatic logic first_bit(input logic [N-1:0] w);
    return LSB_FIRST ? w[0] : w[N-1];
  endfunction

  // shreg always holds the current bit at the output end, so the next
  // bit sits one position inward.
  function automatic logic next_bit(input logic [N-1:0] w);
    return LSB_FIRST ? w[1] : w[N-2];
  endfunction

  function automatic logic [N-1:0] shift(input logic [N-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  bit_counter #(.N(N), .CW(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .enable   (enable),
    .count    (count),
    .terminal (terminal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Ready depends on state/count only, so an accept in the last-bit cycle
  // chains the next word with no gap.
  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    clear      = 1'b0;
    enable     = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = ~reset;
        accept     = load_valid & load_ready;
        if (accept) begin
          next_state = ST_SHIFT;
          clear      = 1'b1;
        end
      end
      ST_SHIFT: begin
        load_ready = ~reset & terminal;
        accept     = load_valid & load_ready;
        if (terminal) begin
          clear      = 1'b1;
          next_state = accept ? ST_SHIFT : ST_IDLE;
        end else begin
          enable = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (accept) begin
      shreg      <= D;
      sout       <= first_bit(D);
      sout_valid <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else if (state == ST_SHIFT && !terminal) begin
      shreg      <= shift(shreg);
      sout       <= next_bit(shreg);
      sout_valid <= 1'b1;
      busy       <= 1'b1;
      done       <= (count == CW'(N - 2));
    end else begin
      shreg      <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench: three instances (N=4 LSB-first, N=4 MSB-first, N=8 LSB-first)
// driven with hand-computed serial sequences.
module tb_piso_shift_register;

  logic       clk;
  logic       reset;
  logic [2:0] lv, rdy, so, sv, bz, dn;
  logic [3:0] d0, d1;
  logic [7:0] d2;

  int tests = 0;
  int fails = 0;

  piso_shift_register #(.N(4), .LSB_FIRST(1'b1)) u0 (
    .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(rdy[0]), .D(d0),
    .sout(so[0]), .sout_valid(sv[0]), .busy(bz[0]), .done(dn[0]));

  piso_shift_register #(.N(4), .LSB_FIRST(1'b0)) u1 (
    .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(rdy[1]), .D(d1),
    .sout(so[1]), .sout_valid(sv[1]), .busy(bz[1]), .done(dn[1]));

  piso_shift_register #(.N(8), .LSB_FIRST(1'b1)) u2 (
    .clk(clk), .reset(reset), .load_valid(lv[2]), .load_ready(rdy[2]), .D(d2),
    .sout(so[2]), .sout_valid(sv[2]), .busy(bz[2]), .done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input string tag, input int u, input logic e_so, input logic e_sv,
                     input logic e_bz, input logic e_dn, input logic e_rdy);
    chk({tag, "/sout"},       32'(so[u]),  32'(e_so));
    chk({tag, "/sout_valid"}, 32'(sv[u]),  32'(e_sv));
    chk({tag, "/busy"},       32'(bz[u]),  32'(e_bz));
    chk({tag, "/done"},       32'(dn[u]),  32'(e_dn));
    chk({tag, "/load_ready"}, 32'(rdy[u]), 32'(e_rdy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e2, e3;
    logic [7:0] e4, e5, e6;
    logic [3:0] tog [4];

    reset = 1'b1; lv = '0; d0 = '0; d1 = '0; d2 = '0;
    #3;
    for (int u = 0; u < 3; u++) cyc("reset", u, 0, 0, 0, 0, 0);
    step(); step();
    reset = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) cyc("reset_rel", u, 0, 0, 0, 0, 1);

    // T2: LSB-first 4'b1011 -> 1,1,0,1
    e2 = 4'b1011;
    d0 = 4'b1011; lv[0] = 1'b1;
    step();
    lv[0] = 1'b0; d0 = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      cyc($sformatf("t2_b%0d", k), 0, e2[k], 1, 1, k == 3, k == 3);
      step();
    end
    cyc("t2_idle", 0, 0, 0, 0, 0, 1);

    // T3: MSB-first 4'b1011 -> 1,0,1,1
    e3 = 4'b1101;
    d1 = 4'b1011; lv[1] = 1'b1;
    step();
    lv[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc($sformatf("t3_b%0d", k), 1, e3[k], 1, 1, k == 3, k == 3);
      step();
    end
    cyc("t3_idle", 1, 0, 0, 0, 0, 1);

    // T4: back-to-back A then 5 -> 0,1,0,1,1,0,1,0
    e4 = 8'b01011010;
    d0 = 4'hA; lv[0] = 1'b1;
    step();
    d0 = 4'h5;
    for (int k = 0; k < 8; k++) begin
      cyc($sformatf("t4_b%0d", k), 0, e4[k], 1, 1, (k == 3) || (k == 7), (k == 3) || (k == 7));
      step();
      if (k == 3) lv[0] = 1'b0;
    end
    cyc("t4_idle", 0, 0, 0, 0, 0, 1);

    // T5: MSB-first, D toggles while not ready; 1100 then 0110
    e5 = 8'b01100011;
    tog[0] = 4'b0011; tog[1] = 4'b1111; tog[2] = 4'b0000; tog[3] = 4'b0110;
    d1 = 4'b1100; lv[1] = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      cyc($sformatf("t5_b%0d", k), 1, e5[k], 1, 1, (k == 3) || (k == 7), (k == 3) || (k == 7));
      if (k < 4) d1 = tog[k];
      step();
      if (k == 3) lv[1] = 1'b0;
    end
    cyc("t5_idle", 1, 0, 0, 0, 0, 1);

    // T6: N=8, 8'h81 -> 1,0,0,0,0,0,0,1
    e6 = 8'b10000001;
    d2 = 8'h81; lv[2] = 1'b1;
    step();
    lv[2] = 1'b0; d2 = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      cyc($sformatf("t6_b%0d", k), 2, e6[k], 1, 1, k == 7, k == 7);
      chk($sformatf("t6_term%0d", k), 32'(u2.terminal), 32'(k == 7));
      step();
    end
    cyc("t6_idle", 2, 0, 0, 0, 0, 1);

    // T1: reset mid-word after two bits of 4'b1011
    d0 = 4'b1011; lv[0] = 1'b1;
    step();
    lv[0] = 1'b0;
    cyc("t1_b0", 0, 1, 1, 1, 0, 0);
    step();
    cyc("t1_b1", 0, 1, 1, 1, 0, 0);
    #3 reset = 1'b1;
    #1 cyc("t1_async", 0, 0, 0, 0, 0, 0);
    step();
    cyc("t1_held", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1 cyc("t1_rel", 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      cyc($sformatf("t1_quiet%0d", k), 0, 0, 0, 0, 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
